// File: rtl/regf_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Default depth, register index width and the buffered entry layout.
package regf_wb_pkg;

  localparam int unsigned WB_DEPTH_DEF = 4;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned DATA_W       = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the live region of the write-back FIFO
// for a single forwarding lookup address.
module wb_fwd_match
  import regf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEF,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [REG_IDX_W-1:0]  addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr != '0) && (entries[idx].rd == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regf_wb_ctrl.sv
// Write-back buffer merging MEM and ALU results into one register-file write port.
// Optional forwarding lookups are built only when WB_FWD_EN is defined.
module regf_wb_ctrl
  import regf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  output logic        WE,
  output logic [4:0]  rW,
  output logic [31:0] W,
  input  logic [4:0]  rA,
  input  logic [4:0]  rB,
  output logic        fwd_hitA,
  output logic [31:0] fwd_dataA,
  output logic        fwd_hitB,
  output logic [31:0] fwd_dataB
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  mem_enq;
  logic                  alu_enq;
  logic                  pop;
  logic [CNT_W-1:0]      n_enq;
  logic [PTR_W-1:0]      alu_slot;

  // Space check uses start-of-cycle count; a same-edge pop never frees room.
  assign mem_ready = (count < CNT_W'(DEPTH));
  assign alu_ready = ((count + CNT_W'(mem_valid)) < CNT_W'(DEPTH));

  // Writes to x0 are handshaken but dropped.
  assign mem_enq  = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_enq  = alu_valid && alu_ready && (alu_rd != '0);
  assign n_enq    = CNT_W'(mem_enq) + CNT_W'(alu_enq);
  assign alu_slot = mem_enq ? (tail + PTR_W'(1)) : tail;
  assign pop      = (count != '0);

  always_ff @(posedge clk) begin
    if (mem_enq) begin
      entries[tail] <= '{rd: mem_rd, data: mem_data};
    end
    if (alu_enq) begin
      entries[alu_slot] <= '{rd: alu_rd, data: alu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(n_enq);
      head  <= head + PTR_W'(pop);
      count <= count + n_enq - CNT_W'(pop);
    end
  end

  assign WE = pop;
  assign rW = pop ? entries[head].rd   : '0;
  assign W  = pop ? entries[head].data : '0;

`ifdef WB_FWD_EN
  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_a (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (rA),
    .hit     (fwd_hitA),
    .data    (fwd_dataA)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_b (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (rB),
    .hit     (fwd_hitB),
    .data    (fwd_dataB)
  );
`else
  assign fwd_hitA  = 1'b0;
  assign fwd_dataA = '0;
  assign fwd_hitB  = 1'b0;
  assign fwd_dataB = '0;
`endif

endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Directed self-checking bench for regf_wb_ctrl; expected forwarding results
// follow whether WB_FWD_EN is defined for the build.
module tb_regf_wb_ctrl;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        WE;
  logic [4:0]  rW;
  logic [31:0] W;
  logic [4:0]  rA;
  logic [4:0]  rB;
  logic        fwd_hitA;
  logic [31:0] fwd_dataA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataB;

  int n_checks = 0;
  int n_fail   = 0;

  regf_wb_ctrl #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .WE        (WE),
    .rW        (rW),
    .W         (W),
    .rA        (rA),
    .rB        (rB),
    .fwd_hitA  (fwd_hitA),
    .fwd_dataA (fwd_dataA),
    .fwd_hitB  (fwd_hitB),
    .fwd_dataB (fwd_dataB)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    rA = 5'd0; rB = 5'd0;
    @(negedge clk);
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", WE); end
    n_checks++; if (rW !== 5'd0) begin n_fail++; $display("FAIL reset_rw got=%0d exp=0", rW); end
    n_checks++; if (W !== 32'd0) begin n_fail++; $display("FAIL reset_w got=%h exp=0", W); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got=%0b exp=1", mem_ready); end
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got=%0b exp=1", alu_ready); end
    n_checks++; if (fwd_hitA !== 1'b0 || fwd_dataA !== 32'd0) begin n_fail++; $display("FAIL reset_fwdA got=%0b/%h exp=0/0", fwd_hitA, fwd_dataA); end
    n_checks++; if (fwd_hitB !== 1'b0 || fwd_dataB !== 32'd0) begin n_fail++; $display("FAIL reset_fwdB got=%0b/%h exp=0/0", fwd_hitB, fwd_dataB); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11; rA = 5'd3;
    @(negedge clk);
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%0b exp=1", mem_ready); end
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL single_we_pre got=%0b exp=0", WE); end
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (WE !== 1'b1 || rW !== 5'd3 || W !== 32'h11) begin n_fail++; $display("FAIL single_write got=%0b/%0d/%h exp=1/3/11", WE, rW, W); end
    n_checks++; if (fwd_hitA !== FWD || fwd_dataA !== (FWD ? 32'h11 : 32'h0)) begin n_fail++; $display("FAIL single_fwd got=%0b/%h", fwd_hitA, fwd_dataA); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL single_we_post got=%0b exp=0", WE); end
    n_checks++; if (fwd_hitA !== 1'b0) begin n_fail++; $display("FAIL single_fwd_post got=%0b exp=0", fwd_hitA); end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hB;
    rA = 5'd5; rB = 5'd6;
    @(negedge clk);
    n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready got=%0b/%0b exp=1/1", mem_ready, alu_ready); end
    next_cycle();
    mem_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (WE !== 1'b1 || rW !== 5'd5 || W !== 32'hA) begin n_fail++; $display("FAIL same_first got=%0b/%0d/%h exp=1/5/a", WE, rW, W); end
    n_checks++; if (fwd_hitA !== FWD || fwd_dataA !== (FWD ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL same_fwd_youngest got=%0b/%h", fwd_hitA, fwd_dataA); end
    n_checks++; if (fwd_hitB !== 1'b0 || fwd_dataB !== 32'h0) begin n_fail++; $display("FAIL same_fwdB_miss got=%0b/%h exp=0/0", fwd_hitB, fwd_dataB); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (WE !== 1'b1 || rW !== 5'd5 || W !== 32'hB) begin n_fail++; $display("FAIL same_second got=%0b/%0d/%h exp=1/5/b", WE, rW, W); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL same_drained got=%0b exp=0", WE); end
    next_cycle();
  endtask

  // Cycle table: both producers push until count saturates at 3, then drain.
  task automatic test_backpressure();
    int mv[8]   = '{1, 1, 1, 0, 0, 0, 0, 0};
    int mrd[8]  = '{1, 3, 5, 0, 0, 0, 0, 0};
    int av[8]   = '{1, 1, 1, 1, 0, 0, 0, 0};
    int ard[8]  = '{2, 4, 6, 6, 0, 0, 0, 0};
    int emr[8]  = '{1, 1, 1, 1, 1, 1, 1, 1};
    int ear[8]  = '{1, 1, 0, 1, 1, 1, 1, 1};
    int erw[8]  = '{0, 1, 2, 3, 4, 5, 6, 0};
    rA = 5'd5; rB = 5'd0;
    for (int c = 0; c < 8; c++) begin
      mem_valid = mv[c][0]; mem_rd = 5'(mrd[c]); mem_data = 32'hD000_0000 | 32'(mrd[c]);
      alu_valid = av[c][0]; alu_rd = 5'(ard[c]); alu_data = 32'hD000_0000 | 32'(ard[c]);
      @(negedge clk);
      n_checks++; if (mem_ready !== emr[c][0]) begin n_fail++; $display("FAIL bp_mem_ready c=%0d got=%0b exp=%0d", c, mem_ready, emr[c]); end
      n_checks++; if (alu_ready !== ear[c][0]) begin n_fail++; $display("FAIL bp_alu_ready c=%0d got=%0b exp=%0d", c, alu_ready, ear[c]); end
      n_checks++; if (WE !== (erw[c] != 0) || rW !== 5'(erw[c]) || W !== ((erw[c] != 0) ? (32'hD000_0000 | 32'(erw[c])) : 32'h0)) begin
        n_fail++; $display("FAIL bp_write c=%0d got=%0b/%0d/%h exp_rd=%0d", c, WE, rW, W, erw[c]);
      end
      if (c == 4) begin
        n_checks++; if (fwd_hitA !== FWD || fwd_dataA !== (FWD ? 32'hD000_0005 : 32'h0)) begin n_fail++; $display("FAIL bp_fwd got=%0b/%h", fwd_hitA, fwd_dataA); end
      end
      next_cycle();
    end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF; rA = 5'd0;
    @(negedge clk);
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
    n_checks++; if (fwd_hitA !== 1'b0) begin n_fail++; $display("FAIL x0_fwd_pre got=%0b exp=0", fwd_hitA); end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%0b exp=0", WE); end
    n_checks++; if (fwd_hitA !== 1'b0 || fwd_dataA !== 32'h0) begin n_fail++; $display("FAIL x0_fwd got=%0b/%h exp=0/0", fwd_hitA, fwd_dataA); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h70;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h80;
    next_cycle();
    mem_rd = 5'd9; mem_data = 32'h90;
    alu_rd = 5'd10; alu_data = 32'hA0;
    next_cycle();
    mem_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (WE !== 1'b1 || rW !== 5'd8 || W !== 32'h80) begin n_fail++; $display("FAIL mid_predrain got=%0b/%0d/%h exp=1/8/80", WE, rW, W); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (WE !== 1'b0 || rW !== 5'd0 || W !== 32'h0) begin n_fail++; $display("FAIL mid_rst_now got=%0b/%0d/%h exp=0/0/0", WE, rW, W); end
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL mid_after c=%0d got=%0b exp=0", c, WE); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_backpressure();
    test_rd_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
